// File: rtl/shift_sequencer.sv
// shift_sequencer: button/tick-driven sequencer owning the rotator pattern register
module shift_sequencer #(
    parameter int CLK_DIV    = 25_000_000,
    parameter int DEB_CYCLES = 250_000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       load_btn,
    input  logic       step_btn,
    input  logic       run_sw,
    input  logic       dir_sw,
    input  logic [9:0] pattern_in,
    input  logic [9:0] shifted,
    output logic [9:0] pattern,
    output logic       direction,
    output logic       shiftEN,
    output logic       busy,
    output logic [7:0] shift_count
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
    state_t        state;
    logic [3:0]    sync1, sync2;
    logic [1:0]    lvl, lvl_d;
    logic [DW-1:0] dcnt [2];
    logic [TW-1:0] tcnt;
    logic          load_p, step_p, tick_p;
    logic          load_ev, step_ev, tick_ev;
    assign load_ev = lvl[0] & ~lvl_d[0];
    assign step_ev = lvl[1] & ~lvl_d[1];
    assign tick_ev = sync2[2] && tcnt == TW'(CLK_DIV - 1);
    // two-stage synchronizers for {dir, run, step, load}
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dir_sw, run_sw, step_btn, load_btn};
            sync2 <= sync1;
        end
    end
    // debounce load/step: adopt the new level after DEB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            lvl   <= '0;
            lvl_d <= '0;
            for (int k = 0; k < 2; k++) dcnt[k] <= '0;
        end else begin
            lvl_d <= lvl;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == lvl[k]) dcnt[k] <= '0;
                else if (dcnt[k] == DW'(DEB_CYCLES - 1)) begin
                    lvl[k]  <= sync2[k];
                    dcnt[k] <= '0;
                end else dcnt[k] <= dcnt[k] + 1'b1;
            end
        end
    end
    // run-mode tick divider, parked at zero while the run switch is off
    always_ff @(posedge CLK) begin
        if (!RSTn || !sync2[2]) tcnt <= '0;
        else tcnt <= tick_ev ? '0 : tcnt + 1'b1;
    end
    // pending flags and the IDLE/SHIFT/CAPTURE sequencer with registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= IDLE;
            pattern     <= 10'h001;
            direction   <= 1'b0;
            shiftEN     <= 1'b0;
            busy        <= 1'b0;
            shift_count <= '0;
            load_p      <= 1'b0;
            step_p      <= 1'b0;
            tick_p      <= 1'b0;
        end else begin
            load_p <= load_p | load_ev;
            step_p <= step_p | step_ev;
            tick_p <= tick_p | tick_ev;
            case (state)
                IDLE: begin
                    if (load_p) begin
                        pattern     <= pattern_in;
                        shift_count <= '0;
                        load_p      <= load_ev;
                        step_p      <= step_ev;
                        tick_p      <= tick_ev;
                    end else if (step_p || tick_p) begin
                        direction <= sync2[3];
                        shiftEN   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                        if (step_p) step_p <= step_ev;
                        else tick_p <= tick_ev;
                    end
                end
                SHIFT: begin
                    shiftEN <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    pattern     <= shifted;
                    shift_count <= shift_count + 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    shiftEN <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized scenario bench against an arithmetic rotate model
module tb_shift_sequencer;
    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       load_btn = 1'b0, step_btn = 1'b0, run_sw = 1'b0, dir_sw = 1'b0;
    logic [9:0] pattern_in = '0;
    logic [9:0] shifted = '0;
    logic [9:0] pattern;
    logic       direction, shiftEN, busy;
    logic [7:0] shift_count;
    int checks = 0, failures = 0;
    int exp_pat = 1, exp_cnt = 0;
    int en_pulses = 0, cyc_n = 0;

    shift_sequencer #(.CLK_DIV(8), .DEB_CYCLES(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .load_btn(load_btn), .step_btn(step_btn),
        .run_sw(run_sw), .dir_sw(dir_sw), .pattern_in(pattern_in), .shifted(shifted),
        .pattern(pattern), .direction(direction), .shiftEN(shiftEN), .busy(busy),
        .shift_count(shift_count)
    );

    always #5 CLK = ~CLK;

    // stand-in for barrel_shifter_10bit: registers the rotation when enabled
    always @(posedge CLK) begin
        if (shiftEN) shifted <= direction ? {pattern[8:0], pattern[9]} : {pattern[0], pattern[9:1]};
    end

    always @(posedge CLK) begin
        cyc_n <= cyc_n + 1;
        if (shiftEN) en_pulses <= en_pulses + 1;
    end

    function automatic int rot(input int p, input bit d);
        return d ? ((p * 2) % 1024 + p / 512) : (p / 2 + (p % 2) * 512);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input logic [9:0] v);
        pattern_in = v;
        load_btn = 1'b1;
        cyc(6);
        load_btn = 1'b0;
        cyc(10);
        exp_pat = int'(v);
        exp_cnt = 0;
        checks++;
        if (pattern !== 10'(exp_pat)) begin
            failures++;
            $display("FAIL load_pattern got %h want %h", pattern, 10'(exp_pat));
        end
        checks++;
        if (shift_count !== 8'd0) begin
            failures++;
            $display("FAIL load_count got %0d want 0", shift_count);
        end
    endtask

    task automatic step_once(input bit d);
        int start, waited;
        dir_sw = d;
        cyc(3);
        start = en_pulses;
        step_btn = 1'b1;
        cyc(6);
        step_btn = 1'b0;
        waited = 0;
        while (!(en_pulses == start + 1 && !busy) && waited < 40) begin
            cyc(1);
            waited++;
        end
        cyc(8);
        exp_pat = rot(exp_pat, d);
        exp_cnt = (exp_cnt + 1) % 256;
        checks++;
        if (en_pulses != start + 1) begin
            failures++;
            $display("FAIL step_pulses got %0d want 1", en_pulses - start);
        end
        checks++;
        if (pattern !== 10'(exp_pat)) begin
            failures++;
            $display("FAIL step_pattern dir=%0d got %h want %h", d, pattern, 10'(exp_pat));
        end
        checks++;
        if (shift_count !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL step_count got %0d want %0d", shift_count, exp_cnt);
        end
        checks++;
        if (direction !== d) begin
            failures++;
            $display("FAIL step_direction got %b want %b", direction, d);
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        cyc(3);
        RSTn = 1'b1;
        cyc(20);
        checks++;
        if (pattern !== 10'h001) begin failures++; $display("FAIL reset_pattern got %h want 001", pattern); end
        checks++;
        if (shiftEN !== 1'b0) begin failures++; $display("FAIL reset_shiften got %b want 0", shiftEN); end
        checks++;
        if (shift_count !== 8'd0) begin failures++; $display("FAIL reset_count got %0d want 0", shift_count); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (direction !== 1'b0) begin failures++; $display("FAIL reset_direction got %b want 0", direction); end
    endtask

    task automatic test_load;
        bit found = 0;
        pattern_in = 10'h2A5;
        load_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (i == 6) load_btn = 1'b0;
            if (pattern === 10'h2A5) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL load_latency got %h want 2a5 within 8 cycles", pattern); end
        cyc(10);
        exp_pat = 'h2A5;
        exp_cnt = 0;
        checks++;
        if (pattern !== 10'h2A5) begin failures++; $display("FAIL load_hold got %h want 2a5", pattern); end
    endtask

    task automatic test_step;
        step_once(1'b1);
        checks++;
        if (pattern !== 10'h14B) begin failures++; $display("FAIL step_left got %h want 14b", pattern); end
        step_once(1'b0);
        checks++;
        if (pattern !== 10'h2A5) begin failures++; $display("FAIL step_right got %h want 2a5", pattern); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(10'($urandom_range(0, 1023)));
            else step_once(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_run;
        int last = 0, waited;
        do_load(10'h200);
        dir_sw = 1'b1;
        cyc(3);
        run_sw = 1'b1;
        for (int k = 0; k < 256; k++) begin
            waited = 0;
            while (!shiftEN && waited < 20) begin
                cyc(1);
                waited++;
            end
            if (!shiftEN) begin
                checks++;
                failures++;
                $display("FAIL run_timeout pulse %0d got none want one within 20 cycles", k);
                break;
            end
            if (k > 0) begin
                checks++;
                if (cyc_n - last != 8) begin
                    failures++;
                    $display("FAIL run_spacing pulse %0d got %0d want 8", k, cyc_n - last);
                end
            end
            last = cyc_n;
            cyc(2);
            exp_pat = rot(exp_pat, 1'b1);
            exp_cnt = (exp_cnt + 1) % 256;
            checks++;
            if (pattern !== 10'(exp_pat)) begin
                failures++;
                $display("FAIL run_pattern pulse %0d got %h want %h", k, pattern, 10'(exp_pat));
            end
        end
        checks++;
        if (shift_count !== 8'd0) begin failures++; $display("FAIL run_wrap got %0d want 0", shift_count); end
        run_sw = 1'b0;
        cyc(12);
    endtask

    task automatic test_bounce;
        int start;
        bit d = 1'($urandom_range(0, 1));
        dir_sw = d;
        cyc(3);
        start = en_pulses;
        step_btn = 1'b1; cyc(1);
        step_btn = 1'b0; cyc(1);
        step_btn = 1'b1; cyc(1);
        step_btn = 1'b0; cyc(1);
        step_btn = 1'b1; cyc(6);
        step_btn = 1'b0;
        cyc(20);
        exp_pat = rot(exp_pat, d);
        exp_cnt = (exp_cnt + 1) % 256;
        checks++;
        if (en_pulses != start + 1) begin failures++; $display("FAIL bounce_pulses got %0d want 1", en_pulses - start); end
        checks++;
        if (pattern !== 10'(exp_pat)) begin failures++; $display("FAIL bounce_pattern got %h want %h", pattern, 10'(exp_pat)); end
    endtask

    task automatic test_load_during_shift;
        int start, old;
        logic [9:0] newv, cap = '0;
        bit d = 1'($urandom_range(0, 1));
        bit pb;
        dir_sw = d;
        newv = 10'($urandom_range(0, 1023));
        cyc(3);
        old = exp_pat;
        start = en_pulses;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) run_sw = 1'b1;
            if (i == 2) step_btn = 1'b1;
            if (i == 4) begin pattern_in = newv; load_btn = 1'b1; end
            if (i == 8) step_btn = 1'b0;
            if (i == 9) run_sw = 1'b0;
            if (i == 10) load_btn = 1'b0;
            pb = busy;
            cyc(1);
            if (pb && !busy) cap = pattern;
        end
        checks++;
        if (en_pulses != start + 1) begin failures++; $display("FAIL overlap_pulses got %0d want 1", en_pulses - start); end
        checks++;
        if (cap !== 10'(rot(old, d))) begin failures++; $display("FAIL overlap_capture got %h want %h", cap, 10'(rot(old, d))); end
        checks++;
        if (pattern !== newv) begin failures++; $display("FAIL overlap_load got %h want %h", pattern, newv); end
        checks++;
        if (shift_count !== 8'd0) begin failures++; $display("FAIL overlap_count got %0d want 0", shift_count); end
        exp_pat = int'(newv);
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid;
        int waited = 0, start;
        dir_sw = 1'b1;
        cyc(3);
        step_btn = 1'b1;
        while (!shiftEN && waited < 20) begin
            cyc(1);
            waited++;
        end
        step_btn = 1'b0;
        checks++;
        if (!shiftEN) begin failures++; $display("FAIL rstmid_timeout got no shiftEN want one within 20 cycles"); end
        RSTn = 1'b0;
        cyc(1);
        checks++;
        if (pattern !== 10'h001) begin failures++; $display("FAIL rstmid_pattern got %h want 001", pattern); end
        checks++;
        if (shiftEN !== 1'b0) begin failures++; $display("FAIL rstmid_shiften got %b want 0", shiftEN); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++;
        if (shift_count !== 8'd0) begin failures++; $display("FAIL rstmid_count got %0d want 0", shift_count); end
        cyc(2);
        RSTn = 1'b1;
        start = en_pulses;
        cyc(12);
        checks++;
        if (pattern !== 10'h001) begin failures++; $display("FAIL rstmid_nocapture got %h want 001", pattern); end
        checks++;
        if (en_pulses != start) begin failures++; $display("FAIL rstmid_spurious got %0d want 0", en_pulses - start); end
        exp_pat = 1;
        exp_cnt = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_random();
        test_run();
        test_bounce();
        test_load_during_shift();
        test_reset_mid();
        step_once(1'($urandom_range(0, 1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Control stage directly upstream of `barrel_shifter_10bit`. Owns the 10-bit pattern register that drives the rotator's `in`, and issues `shiftEN`/`direction` requests from debounced push-buttons, a run switch and a programmable tick. Captures the rotator's registered `out` back into the pattern, closing the rotate loop. Also exposes the pattern for LED display.

## Interface
- `CLK_DIV`, default 25_000_000: run-mode tick period in CLK cycles (≥ 4).
- `DEB_CYCLES`, default 250_000: debounce stability window in CLK cycles (≥ 2).
- `CLK` in 1: single clock, all logic on rising edge.
- `RSTn` in 1: reset, synchronous, active-low.
- `load_btn` in 1: raw button; load `pattern_in`.
- `step_btn` in 1: raw button; one single rotation.
- `run_sw` in 1: raw switch; 1 = rotate once per tick.
- `dir_sw` in 1: raw switch; 1 = rotate toward MSB (`out[i]=in[i-1]`), 0 = toward LSB.
- `pattern_in` in 10: switch value for load.
- `shifted` in 10: rotator `out`.
- `pattern` out 10: to rotator `in` and LEDs.
- `direction` out 1: to rotator.
- `shiftEN` out 1: to rotator.
- `busy` out 1: high in SHIFT or CAPTURE.
- `shift_count` out 8: completed rotations since last load/reset, wraps 255→0.

## Operation
- Input conditioning:
  - All four raw inputs pass through 2-FF synchronizers.
  - `load_btn` and `step_btn` are then debounced. The debounced level takes the synchronized value only after it has differed from the current level for `DEB_CYCLES` consecutive cycles. A counter resets on any agreement.
  - A rising edge of a debounced level produces a one-cycle event (`load_ev`, `step_ev`).
- Tick counter:
  - While synchronized `run_sw`=1, counts 0..`CLK_DIV`-1. At `CLK_DIV`-1 it pulses `tick_ev` and wraps to 0.
  - While `run_sw`=0, held at 0.
- Pending flags (one deep each): `load_p`, `step_p`, `tick_p`.
  - Set by their event. Repeat events while set are dropped.
  - Cleared when serviced.
  - Servicing a load also clears `step_p` and `tick_p`.
- FSM states:
  - IDLE:
    - If `load_p`: `pattern` ← `pattern_in`, `shift_count` ← 0, stay IDLE.
    - Else if `step_p` or `tick_p`: latch synchronized `dir_sw` into `direction`, clear one flag (step before tick), go SHIFT.
  - SHIFT: `shiftEN`=1 for exactly this cycle. `pattern` and `direction` held. Go CAPTURE.
  - CAPTURE: `shiftEN`=0, `pattern` ← `shifted`, `shift_count` += 1 (mod 256). Go IDLE.
- Priority in IDLE: load > step > tick.
- Events arriving in SHIFT/CAPTURE only set flags. They are serviced on return to IDLE, so load never corrupts an in-flight rotation.
- `direction` changes only on IDLE→SHIFT. Toggling `dir_sw` mid-rotation affects only the next rotation.
- Reset (any cycle, including mid-rotation):
  - `pattern`=10'b00_0000_0001, `direction`=0, `shiftEN`=0, `busy`=0, `shift_count`=0.
  - FSM to IDLE; all flags, debounce levels and counters to 0.
  - The rotator's stale `out` is ignored because CAPTURE is not reached.

## Timing
- `shiftEN` is registered and high for exactly one cycle per rotation.
- The rotator registers on the edge ending SHIFT. `shifted` is sampled on the edge ending CAPTURE.
- Rotation cost is 3 cycles IDLE→IDLE. Minimum spacing between `shiftEN` pulses is 3 cycles.
- Load latency: `load_p` set to `pattern` updated is 1 cycle, when IDLE.
- Button latency: raw edge to event is 2 (sync) + `DEB_CYCLES` + 1 cycles. Event to `shiftEN` high is 2 cycles (flag set, then IDLE→SHIFT).
- Run mode: one rotation per `CLK_DIV` cycles, steady state.
- `busy` equals (state≠IDLE), registered with the state.

## Test plan
Bench instantiates `barrel_shifter_10bit` on the outputs. Use `CLK_DIV`=8, `DEB_CYCLES`=3.
- Reset, then idle 20 cycles → `pattern`=0x001, `shiftEN`=0, `shift_count`=0, `busy`=0.
- `pattern_in`=0x2A5, press `load_btn` 6 cycles → `pattern`=0x2A5 within 8 cycles of press. `step_btn` with `dir_sw`=1 → `pattern`=0x14B, `shift_count`=1. `dir_sw`=0 step → 0x2A5.
- `run_sw`=1, `dir_sw`=1, `pattern`=0x200 → `shiftEN` pulses every 8 cycles, `pattern` sequence 0x001, 0x002, 0x004. After 256 rotations `shift_count` wraps to 0.
- Bounce `step_btn` (1,0,1,0 single cycles) then hold 6 cycles → exactly one rotation.
- `load_ev` and `tick_ev` land in SHIFT → rotation completes with the old pattern. Next IDLE loads `pattern_in`, pending tick is discarded, `shift_count`=0.
- Assert `RSTn`=0 during SHIFT → next cycle `pattern`=0x001, `shiftEN`=0, `busy`=0, no capture of `shifted`.
